led_rotator: RTL
================

// Module: led_rotator
// PURPOSE
//  Parametrised one-hot LED rotator: next generation of the 4-LED enable-stepped blinker.
//  Single clock domain; button/enable input is synchronised and edge-detected, no longer used as a clock.
//  Adds an N-LED width, left/right direction, auto-rotate from an internal prescaler, bounce (ping-pong) and hold modes.
//  Sits between board pins (button, mode straps) and the LED bank on the iCEstick top level.
// PARAMETERS
//  NUM_LEDS    4   number of LEDs in the ring; NUM_LEDS >= 1
//  PRESCALE_W  24  width of the prescaler counter and of the period port
// PORTS
//  clk       in   1                   system clock (12 MHz on iCEstick)
//  reset     in   1                   synchronous, active-high reset
//  step_in   in   1                   asynchronous step request (button); a rising edge = one step in MANUAL
//  mode      in   2                   00 MANUAL, 01 AUTO, 10 BOUNCE, 11 HOLD
//  dir       in   1                   0 = left (toward MSB), 1 = right (toward LSB)
//  period    in   PRESCALE_W          auto/bounce step period in clk cycles; 0 is treated as 1
//  leds      out  NUM_LEDS            one-hot LED drive
//  pos       out  max(1,$clog2(N))    index of the lit LED
//  step_ack  out  1                   1-cycle pulse on every cycle in which leds changes
// BEHAVIOUR
//  Reset (synchronous, sampled at a clk rising edge):
//  - leds = 1 (bit 0); pos = 0; step_ack = 0.
//  - prescaler = 0; synchroniser/edge flops = 0; bounce direction = left.
//  - Pending synchronised edges are discarded.
//  Input sync:
//  - step_in passes through 2 flops (s1, s2), then s3 = delayed s2; edge = s2 & ~s3.
//  - leds updates at the 3rd clk edge after step_in is first sampled high.
//  - A held-high step_in gives exactly one step; re-arms only after step_in is sampled low.
//  Prescaler (AUTO/BOUNCE only):
//  - Counts 0..P-1, where P = (period==0) ? 1 : period.
//  - tick asserts when count == P-1; count then wraps to 0.
//  - Held at 0 in MANUAL/HOLD.
//  - If period is lowered below the current count, tick fires at the next wrap of the full width. Software must change period only in MANUAL/HOLD.
//  Step rules:
//  - Left: leds <= {leds[N-2:0], leds[N-1]}; right: mirror. Wrap-around N-1 -> 0 (left) and 0 -> N-1 (right).
//  - MANUAL: one step per detected edge, direction from dir; tick ignored.
//  - AUTO: one step per tick, direction from dir; step edges ignored.
//  - BOUNCE: one step per tick using the internal bounce direction; no wrap.
//    - At pos N-1 moving left: step to N-2 and flip to right.
//    - At pos 0 moving right: step to 1 and flip to left.
//    - On entry to BOUNCE, bounce direction is loaded from dir.
//  - HOLD: leds frozen; edges and ticks ignored.
//  - NUM_LEDS == 1: leds constant 1; step_ack still pulses on each accepted step.
//  - mode/dir changes take effect at the next clk edge. Edges arriving while not in MANUAL are dropped, not queued.
//  pos and step_ack are registered and coherent with leds (same cycle). leds is always exactly one-hot.
// STRUCTURE
//  - led_pkg: mode encodings MODE_MANUAL/AUTO/BOUNCE/HOLD, DIR_LEFT/DIR_RIGHT.
//  - Sub-module tick_prescaler (clk, reset, en, period -> tick) instantiated once.
//  - Synchroniser, edge detect and rotate/bounce logic stay in led_rotator.
// TESTING
//  1 reset mid-rotation (leds=0100) -> next edge: leds=0001, pos=0, prescaler 0, no step_ack.
//  2 MANUAL, dir=0, step_in high for 1, 4 and 10 cycles (each then low) -> exactly one step each: 0001->0010->0100->1000; 4th step wraps to 0001; step_ack lands 3 cycles after each rise.
//  3 AUTO, period=5, dir=1 -> step every 5 clks: 0001->1000->0100->0010; period=0 -> step every clk.
//  4 BOUNCE, N=4, period=1, dir=0 -> pos sequence 0,1,2,3,2,1,0,1; step_ack every cycle.
//  5 HOLD with step_in toggling and period=1 -> leds/pos unchanged, step_ack stays 0; return to MANUAL without a new edge -> no step.
//  6 NUM_LEDS=8 and NUM_LEDS=1 builds -> 8-step full wrap returns to 0x01; N=1 leds stays 1.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the LED rotator: operating modes and rotation directions.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;  // toward MSB
    localparam logic DIR_RIGHT = 1'b1;  // toward LSB

endpackage

// File: rtl/led_rotator_tick_prescaler.sv
// Free-running step-period prescaler: counts 0..P-1 while enabled and flags the
// last count. A period of 0 behaves as 1 (tick every cycle). If the period is
// lowered below the running count, the counter runs on to its natural full-width
// wrap before it can match again.
module tick_prescaler
    import led_pkg::*;
#(
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] period,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count_q;
    logic [PRESCALE_W-1:0] count_d;
    logic [PRESCALE_W-1:0] last_s;
    logic                  tick_s;

    // Next-count and terminal-count detection.
    always_comb begin
        count_d = count_q;
        tick_s  = 1'b0;
        if (period == {PRESCALE_W{1'b0}}) begin
            last_s = {PRESCALE_W{1'b0}};
        end else begin
            last_s = period - PRESCALE_W'(1);
        end
        if (!en) begin
            count_d = {PRESCALE_W{1'b0}};
        end else if (count_q == last_s) begin
            tick_s  = 1'b1;
            count_d = {PRESCALE_W{1'b0}};
        end else begin
            count_d = count_q + PRESCALE_W'(1);
        end
    end

    // Counter state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {PRESCALE_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/led_rotator.sv
// One-hot LED rotator. The button input is synchronised and rising-edge
// detected in the clk domain; steps come from button edges (MANUAL) or the
// prescaler tick (AUTO / BOUNCE). The lit position is the primary state and
// the LED vector is decoded from it, so leds is one-hot by construction.
module led_rotator
    import led_pkg::*;
#(
    parameter  int NUM_LEDS   = 4,
    parameter  int PRESCALE_W = 24,
    localparam int POS_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step_in,
    input  logic [1:0]            mode,
    input  logic                  dir,
    input  logic [PRESCALE_W-1:0] period,
    output logic [NUM_LEDS-1:0]   leds,
    output logic [POS_W-1:0]      pos,
    output logic                  step_ack
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);

    // Synchroniser / edge-detect chain.
    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Rotator state.
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                step_ack_q, step_ack_d;
    logic                bounce_dir_q, bounce_dir_d;
    logic [1:0]          mode_q, mode_d;

    mode_e mode_s;
    logic  step_edge_s;
    logic  tick_s;
    logic  presc_en_s;
    logic  do_step_s;
    logic  step_dir_s;
    logic  bounce_entry_s;

    tick_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (presc_en_s),
        .period(period),
        .tick  (tick_s)
    );

    // Mode decode, step source selection and next-position computation.
    always_comb begin
        mode_s         = mode_e'(mode);
        s1_d           = step_in;
        s2_d           = s1_q;
        s3_d           = s2_q;
        step_edge_s    = s2_q & ~s3_q;
        mode_d         = mode;
        bounce_entry_s = (mode_s == MODE_BOUNCE) && (mode_q != MODE_BOUNCE);
        presc_en_s     = (mode_s == MODE_AUTO) || (mode_s == MODE_BOUNCE);
        do_step_s      = 1'b0;
        step_dir_s     = dir;
        pos_d          = pos_q;

        // Bounce direction is captured from dir when BOUNCE is entered.
        if (bounce_entry_s) begin
            bounce_dir_d = dir;
        end else begin
            bounce_dir_d = bounce_dir_q;
        end

        case (mode_s)
            MODE_MANUAL: begin
                do_step_s  = step_edge_s;
                step_dir_s = dir;
            end
            MODE_AUTO: begin
                do_step_s  = tick_s;
                step_dir_s = dir;
            end
            MODE_BOUNCE: begin
                do_step_s  = tick_s;
                step_dir_s = bounce_dir_d;
            end
            MODE_HOLD: begin
                do_step_s  = 1'b0;
                step_dir_s = dir;
            end
            default: begin
                do_step_s  = 1'b0;
                step_dir_s = dir;
            end
        endcase

        if (do_step_s) begin
            if (mode_s == MODE_BOUNCE) begin
                // Reflect at the ends instead of wrapping.
                if (step_dir_s == DIR_LEFT) begin
                    if (pos_q == LAST_POS) begin
                        pos_d        = LAST_POS - POS_W'(1);
                        bounce_dir_d = DIR_RIGHT;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end else begin
                    if (pos_q == {POS_W{1'b0}}) begin
                        pos_d        = POS_W'(1);
                        bounce_dir_d = DIR_LEFT;
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                    end
                end
            end else begin
                // Ring rotation with wrap-around.
                if (step_dir_s == DIR_LEFT) begin
                    if (pos_q == LAST_POS) begin
                        pos_d = {POS_W{1'b0}};
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end else begin
                    if (pos_q == {POS_W{1'b0}}) begin
                        pos_d = LAST_POS;
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                    end
                end
            end
        end else begin
            pos_d = pos_q;
        end

        // A single-LED ring has nowhere to go; the step is still acknowledged.
        if (NUM_LEDS == 1) begin
            pos_d = {POS_W{1'b0}};
        end else begin
            pos_d = pos_d;
        end

        step_ack_d = do_step_s;

        leds_d = {NUM_LEDS{1'b0}};
        for (int i = 0; i < NUM_LEDS; i++) begin
            leds_d[i] = (pos_d == POS_W'(i));
        end
    end

    // All state registers; reset discards any edge in flight in the synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            pos_q        <= {POS_W{1'b0}};
            leds_q       <= NUM_LEDS'(1);
            step_ack_q   <= 1'b0;
            bounce_dir_q <= DIR_LEFT;
            mode_q       <= MODE_MANUAL;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            pos_q        <= pos_d;
            leds_q       <= leds_d;
            step_ack_q   <= step_ack_d;
            bounce_dir_q <= bounce_dir_d;
            mode_q       <= mode_d;
        end
    end

    assign leds     = leds_q;
    assign pos      = pos_q;
    assign step_ack = step_ack_q;

endmodule
